ctrl_tx: RTL and testbench

CTRL_TX -- requirements
Module: ctrl_tx

---
 rtl/ctrl_pkg.sv | 26 ++
 rtl/ctrl_tx.sv | 131 +++++++++++++
 tb/tb_ctrl_tx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : shared control-word layout and transmitter state encoding
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam int CTRL_W         = 16;

  localparam int CTRL_RESET     = 0;
  localparam int CTRL_ENABLE    = 1;
  localparam int CTRL_SPEED_LSB = 2;
  localparam int CTRL_SPEED_MSB = 3;
  localparam int CTRL_TEST      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_tx.sv
// ============================================================================
// ctrl_tx : serialises a W-bit control word MSB first on ctrl_clk/ctrl_data,
//           followed by a fixed idle gap before the next word is accepted.
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module ctrl_tx
  import ctrl_pkg::*;
#(
  parameter int W   = CTRL_W,
  parameter int DIV = 4,
  parameter int GAP = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic         ctrl_clk_o,
  output logic         ctrl_data_o,
  output logic         busy_o
);

  localparam int HW = $clog2(DIV + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam int BW = $clog2(W + 1);

  // The first low phase carries one extra cycle so the first bit is set up
  // a full DIV cycles after it appears on ctrl_data_o.
  localparam logic [HW-1:0] FIRST_LOAD = HW'(DIV);
  localparam logic [HW-1:0] HALF_LOAD  = HW'(DIV - 1);
  localparam logic [HW-1:0] HALF_ONE   = HW'(1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_ONE    = GW'(1);
  localparam logic [BW-1:0] BITS_LOAD  = BW'(W);
  localparam logic [BW-1:0] BITS_ONE   = BW'(1);

  tx_state_t     state;
  logic [HW-1:0] half_cnt;
  logic [GW-1:0] gap_cnt;
  logic [BW-1:0] bit_cnt;
  logic [W-1:0]  shreg;
  logic [W-1:0]  shreg_next;
  logic          accept;

  assign accept     = valid_i && ready_o;
  assign shreg_next = shreg << 1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      ready_o     <= 1'b0;
      busy_o      <= 1'b1;
      ctrl_clk_o  <= 1'b0;
      ctrl_data_o <= 1'b0;
      half_cnt    <= '0;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
    end else begin
      case (state)
        ST_LOW: begin
          ctrl_clk_o  <= 1'b0;
          ctrl_data_o <= shreg[W-1];
          if (half_cnt == '0) begin
            state      <= ST_HIGH;
            ctrl_clk_o <= 1'b1;
            half_cnt   <= HALF_LOAD;
          end else begin
            half_cnt <= half_cnt - HALF_ONE;
          end
        end

        ST_HIGH: begin
          ctrl_clk_o <= 1'b1;
          if (half_cnt == '0) begin
            ctrl_clk_o <= 1'b0;
            half_cnt   <= HALF_LOAD;
            if (bit_cnt == BITS_ONE) begin
              state       <= ST_GAP;
              ctrl_data_o <= 1'b0;
              gap_cnt     <= GAP_LOAD;
              bit_cnt     <= '0;
              shreg       <= '0;
            end else begin
              // Next bit goes out on the same edge the clock falls.
              state       <= ST_LOW;
              shreg       <= shreg_next;
              ctrl_data_o <= shreg_next[W-1];
              bit_cnt     <= bit_cnt - BITS_ONE;
            end
          end else begin
            half_cnt <= half_cnt - HALF_ONE;
          end
        end

        ST_GAP: begin
          ctrl_clk_o  <= 1'b0;
          ctrl_data_o <= 1'b0;
          if (gap_cnt == '0) begin
            state   <= ST_IDLE;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end

        default: begin
          ctrl_clk_o  <= 1'b0;
          ctrl_data_o <= 1'b0;
          if (accept) begin
            state    <= ST_LOW;
            shreg    <= data_i;
            half_cnt <= FIRST_LOAD;
            bit_cnt  <= BITS_LOAD;
            ready_o  <= 1'b0;
            busy_o   <= 1'b1;
          end else begin
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_tx.sv
// ============================================================================
// tb_ctrl_tx : self-checking bench for ctrl_tx, two parameterisations side by
//              side, compared cycle by cycle against an arithmetic waveform model.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module tb_ctrl_tx;
  import ctrl_pkg::*;

  logic        clk;
  logic [1:0]  rst;
  logic [1:0]  vld;
  logic [15:0] din [2];
  logic [1:0]  rdy, cck, cdt, bsy;

  int n_checks = 0;
  int n_pass   = 0;

  ctrl_tx #(.W(16), .DIV(2), .GAP(4)) u_a (
    .clk_i(clk), .reset_i(rst[0]), .data_i(din[0]), .valid_i(vld[0]),
    .ready_o(rdy[0]), .ctrl_clk_o(cck[0]), .ctrl_data_o(cdt[0]), .busy_o(bsy[0])
  );

  ctrl_tx #(.W(16), .DIV(1), .GAP(1)) u_b (
    .clk_i(clk), .reset_i(rst[1]), .data_i(din[1]), .valid_i(vld[1]),
    .ready_o(rdy[1]), .ctrl_clk_o(cck[1]), .ctrl_data_o(cdt[1]), .busy_o(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  function automatic int div_of(input int b);
    return (b == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(input int b);
    return (b == 0) ? 4 : 1;
  endfunction

  // Expected {ready, ctrl_clk, ctrl_data} k cycles after the accepting edge.
  function automatic logic [2:0] model(input int k, input int div, input int gap,
                                       input logic [15:0] w);
    int   span;
    logic r, c, d;
    span = 2 * div * 16;
    r = (k >= 1 + span + gap);
    c = 1'b0;
    d = 1'b0;
    if (k >= 1 && k < 1 + span) begin
      c = (((k - 1) / div) % 2) == 1;
      d = w[15 - (k - 1) / (2 * div)];
    end
    return {r, c, d};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic wait_ready(input int b);
    int t = 0;
    while (!rdy[b] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_before_send", int'(rdy[b]), 1);
  endtask

  // Sends one word and checks every cycle until ready returns. Called at the
  // sample point (#1 after a rising clk edge).
  task automatic run_frame(input int b, input logic [15:0] w, input bit chained,
                           input bit hold, input logic [15:0] nxt, input bit pulse,
                           output int lat, output int rises, output logic [15:0] got);
    int         div = div_of(b);
    int         gap = gap_of(b);
    int         k;
    logic       prev;
    logic [2:0] e;
    if (!chained) begin
      wait_ready(b);
      din[b] = w;
      vld[b] = 1'b1;
    end
    @(posedge clk); #1;
    if (hold) din[b] = nxt;
    else vld[b] = 1'b0;
    k = 0; rises = 0; got = '0; prev = 1'b0; lat = -1;
    while (k < 400) begin
      e = model(k, div, gap, w);
      check("wave", int'({rdy[b], bsy[b], cck[b], cdt[b]}),
            int'({e[2], !e[2], e[1], e[0]}));
      if (cck[b] && !prev) begin
        rises++;
        got = {got[14:0], cdt[b]};
      end
      prev = cck[b];
      if (rdy[b]) begin
        lat = k;
        break;
      end
      if (pulse) begin
        if (k == 10) begin
          din[b] = ~w;
          vld[b] = 1'b1;
        end else if (k == 13) begin
          vld[b] = 1'b0;
        end
      end
      @(posedge clk); #1;
      k++;
    end
    if (lat < 0) check("frame_timeout", 0, 1);
  endtask

  typedef struct {
    int          b;
    logic [15:0] w;
    bit          pulse;
    int          lat;
    logic [1:0]  speed;
    logic        en;
  } vec_t;

  initial begin
    vec_t        vt [5];
    int          lat, rises, cnt;
    logic [15:0] got;

    vt[0] = '{0, 16'h0013, 1'b0, 69, 2'b00, 1'b1};
    vt[1] = '{0, 16'h001B, 1'b0, 69, 2'b10, 1'b1};
    vt[2] = '{1, 16'hA5A5, 1'b0, 34, 2'b01, 1'b0};
    vt[3] = '{0, 16'h1234, 1'b1, 69, 2'b01, 1'b0};
    vt[4] = '{1, 16'h8001, 1'b1, 34, 2'b00, 1'b0};

    rst = 2'b11; vld = 2'b00; din[0] = '0; din[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++)
      check("reset_outputs", int'({rdy[b], bsy[b], cck[b], cdt[b]}), 4'b0100);
    rst = 2'b00;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++)
      check("ready_after_reset", int'({rdy[b], bsy[b]}), 2'b10);

    for (int i = 0; i < 5; i++) begin
      run_frame(vt[i].b, vt[i].w, 1'b0, 1'b0, 16'h0, vt[i].pulse, lat, rises, got);
      check("latency", lat, vt[i].lat);
      check("rises", rises, 16);
      check("word", int'(got), int'(vt[i].w));
      check("speed", int'(got[CTRL_SPEED_MSB:CTRL_SPEED_LSB]), int'(vt[i].speed));
      check("enable", int'(got[CTRL_ENABLE]), int'(vt[i].en));
    end

    // valid held high across two frames
    run_frame(0, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, lat, rises, got);
    check("b2b_word1", int'(got), 16'hFFFF);
    check("b2b_lat1", lat, 69);
    run_frame(0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b0, lat, rises, got);
    check("b2b_word2", int'(got), 16'h0000);
    check("b2b_rises2", rises, 16);

    // reset in the middle of a frame, after the 5th rising edge
    wait_ready(0);
    din[0] = 16'hFFFF; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    rises = 0; cnt = 0;
    while (rises < 5 && cnt < 100) begin
      @(posedge clk); #1;
      if (cck[0] && !u_a_prev_clk()) rises++;
      cnt++;
    end
    check("fifth_rise_seen", rises, 5);
    #2 rst[0] = 1'b1;
    #1;
    check("async_reset_outputs", int'({rdy[0], bsy[0], cck[0], cdt[0]}), 4'b0100);
    rises = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (cck[0]) rises++;
    end
    rst[0] = 1'b0;
    @(posedge clk); #1;
    check("ready_after_midframe_reset", int'({rdy[0], bsy[0]}), 2'b10);
    repeat (20) begin
      @(posedge clk); #1;
      if (cck[0]) rises++;
    end
    check("no_edges_after_reset", rises, 0);

    // randomized frames on both parameterisations
    for (int i = 0; i < 12; i++) begin
      int          b;
      logic [15:0] w;
      bit          p;
      b = int'($urandom_range(0, 1));
      w = 16'($urandom);
      p = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run_frame(b, w, 1'b0, 1'b0, 16'h0, p, lat, rises, got);
      check("rand_word", int'(got), int'(w));
      check("rand_rises", rises, 16);
      check("rand_latency", lat, 1 + 2 * div_of(b) * 16 + gap_of(b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Value of instance A's ctrl_clk at the previous sample point.
  logic a_clk_prev;
  always @(posedge clk) a_clk_prev <= cck[0];

  function automatic logic u_a_prev_clk();
    return a_clk_prev;
  endfunction

endmodule

`default_nettype wire
